// File: rtl/mfp_multi_digit_display.sv
// mfp_multi_digit_display
//   Hex display driver for N_DIGITS seven-segment digits. A load strobe
//   captures number/dots/blink atomically; the display only ever reads the
//   captured copies. Supports leading-zero blanking, per-digit decimal
//   points, per-digit blink, and either static or time-multiplexed output.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   load            capture number/dots/blink on this edge
//   number          packed hex value, nibble i = digit i (digit 0 rightmost)
//   dots, blink     per-digit decimal-point request / blink enable
//   lz_blank        live leading-zero blanking enable
//   all_segments    static: {g..a} per digit, active-low (all 1s when scanned)
//   all_dots        static: dot per digit, active-low (all 1s when scanned)
//   seven_segments  scanned: {g..a} of selected digit (7'h7f when static)
//   dot             scanned: dot of selected digit (1 when static)
//   anodes          scanned: one-hot-low digit enable (all 1s when static)
module mfp_multi_digit_display #(
    parameter int N_DIGITS    = 6,
    parameter int SCANNED     = 0,
    parameter int SCAN_DIV_W  = 16,
    parameter int BLINK_DIV_W = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   number,
    input  logic [N_DIGITS-1:0]     dots,
    input  logic [N_DIGITS-1:0]     blink,
    input  logic                    lz_blank,
    output logic [7*N_DIGITS-1:0]   all_segments,
    output logic [N_DIGITS-1:0]     all_dots,
    output logic [6:0]              seven_segments,
    output logic                    dot,
    output logic [N_DIGITS-1:0]     anodes
);

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h18;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0e;
        endcase
    endfunction

    logic [4*N_DIGITS-1:0]  number_r;
    logic [N_DIGITS-1:0]    dots_r;
    logic [N_DIGITS-1:0]    blink_r;
    logic [BLINK_DIV_W-1:0] blink_cnt;
    logic                   phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            number_r  <= '0;
            dots_r    <= '0;
            blink_r   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (load) begin
                number_r <= number;
                dots_r   <= dots;
                blink_r  <= blink;
            end
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt)
                phase <= ~phase;
        end
    end

    // Per-digit glyph and dot, from latched state only (lz_blank is live).
    logic [6:0]          seg_c [N_DIGITS];
    logic [N_DIGITS-1:0] dot_c;

    always_comb begin
        logic hi_zero;
        logic dark;
        hi_zero = 1'b1;
        dark    = 1'b0;
        seg_c   = '{default: 7'h7f};
        dot_c   = '1;
        // Walk from the most significant digit down; hi_zero stays set while
        // every nibble from the top through digit i is zero.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hi_zero  = hi_zero & (number_r[4*i +: 4] == 4'h0);
            dark     = blink_r[i] & phase;
            seg_c[i] = ((lz_blank && (i != 0) && hi_zero) || dark)
                       ? 7'h7f : glyph(number_r[4*i +: 4]);
            // A leading-zero blanked digit keeps its dot; a blink-dark one does not.
            dot_c[i] = dark ? 1'b1 : ~dots_r[i];
        end
    end

    if (SCANNED == 0) begin : g_static
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                all_segments <= '1;
                all_dots     <= '1;
            end else begin
                for (int i = 0; i < N_DIGITS; i++)
                    all_segments[7*i +: 7] <= seg_c[i];
                all_dots <= dot_c;
            end
        end
        assign seven_segments = 7'h7f;
        assign dot            = 1'b1;
        assign anodes         = '1;
    end else begin : g_scan
        localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

        logic [SCAN_DIV_W-1:0] presc;
        logic [IDX_W-1:0]      idx;
        logic                  scan_tick;

        // Tick on the cycle whose closing edge wraps the prescaler to 0.
        assign scan_tick = &presc;

        // Anode, segments and dot are all registered from the same idx and
        // latched data, so they change together on one edge: no ghosting.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                presc          <= '0;
                idx            <= '0;
                anodes         <= '1;
                seven_segments <= 7'h7f;
                dot            <= 1'b1;
            end else begin
                presc <= presc + 1'b1;
                if (scan_tick)
                    idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
                anodes         <= ~(N_DIGITS'(1) << idx);
                seven_segments <= seg_c[idx];
                dot            <= dot_c[idx];
            end
        end
        assign all_segments = '1;
        assign all_dots     = '1;
    end

endmodule

// File: tb/tb_mfp_multi_digit_display.sv
module tb_mfp_multi_digit_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, lz_blank;
    logic [23:0] number;
    logic [5:0]  dots, blink;
    logic [11:0] number3;
    logic [3:0]  number1;

    logic [41:0] st_seg;  logic [5:0] st_dots;  logic [6:0] st_7;  logic st_dot;  logic [5:0] st_an;
    logic [41:0] sc_seg;  logic [5:0] sc_dots;  logic [6:0] sc_7;  logic sc_dot;  logic [5:0] sc_an;
    logic [20:0] s3_seg;  logic [2:0] s3_dots;  logic [6:0] s3_7;  logic s3_dot;  logic [2:0] s3_an;
    logic [6:0]  s1_seg;  logic       s1_dots;  logic [6:0] s1_7;  logic s1_dot;  logic       s1_an;

    mfp_multi_digit_display #(.N_DIGITS(6), .SCANNED(0), .SCAN_DIV_W(2), .BLINK_DIV_W(3)) u_st (
        .clk(clk), .rst(rst), .load(load), .number(number), .dots(dots), .blink(blink),
        .lz_blank(lz_blank), .all_segments(st_seg), .all_dots(st_dots),
        .seven_segments(st_7), .dot(st_dot), .anodes(st_an));

    mfp_multi_digit_display #(.N_DIGITS(6), .SCANNED(1), .SCAN_DIV_W(2), .BLINK_DIV_W(3)) u_sc (
        .clk(clk), .rst(rst), .load(load), .number(number), .dots(dots), .blink(blink),
        .lz_blank(lz_blank), .all_segments(sc_seg), .all_dots(sc_dots),
        .seven_segments(sc_7), .dot(sc_dot), .anodes(sc_an));

    mfp_multi_digit_display #(.N_DIGITS(3), .SCANNED(1), .SCAN_DIV_W(2), .BLINK_DIV_W(3)) u_s3 (
        .clk(clk), .rst(rst), .load(load), .number(number3), .dots(3'b000), .blink(3'b000),
        .lz_blank(lz_blank), .all_segments(s3_seg), .all_dots(s3_dots),
        .seven_segments(s3_7), .dot(s3_dot), .anodes(s3_an));

    mfp_multi_digit_display #(.N_DIGITS(1), .SCANNED(1), .SCAN_DIV_W(2), .BLINK_DIV_W(3)) u_s1 (
        .clk(clk), .rst(rst), .load(load), .number(number1), .dots(1'b0), .blink(1'b0),
        .lz_blank(lz_blank), .all_segments(s1_seg), .all_dots(s1_dots),
        .seven_segments(s1_7), .dot(s1_dot), .anodes(s1_an));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scan steps starting at digit 1: number=543210, number3=210.
    logic [5:0] an6_t [7] = '{6'h3d, 6'h3b, 6'h37, 6'h2f, 6'h1f, 6'h3e, 6'h3d};
    logic [6:0] sg6_t [7] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h40, 7'h79};
    logic [2:0] an3_t [7] = '{3'b101, 3'b011, 3'b110, 3'b101, 3'b011, 3'b110, 3'b101};
    logic [6:0] sg3_t [7] = '{7'h79, 7'h24, 7'h40, 7'h79, 7'h24, 7'h40, 7'h79};

    initial begin
        int n;
        rst = 1'b1; load = 1'b0; lz_blank = 1'b0;
        number = '0; dots = '0; blink = '0; number3 = '0; number1 = '0;
        repeat (2) @(negedge clk);

        // Reset state: everything dark.
        chk("rst_st_seg",  st_seg,  {42{1'b1}});
        chk("rst_st_dots", st_dots, 6'h3f);
        chk("rst_sc_an",   sc_an,   6'h3f);
        chk("rst_sc_7",    sc_7,    7'h7f);
        chk("rst_sc_dot",  sc_dot,  1'b1);

        // Release and load scan data on the first edge.
        rst = 1'b0; load = 1'b1;
        number = 24'h543210; number3 = 12'h210; number1 = 4'hb;
        @(negedge clk);
        load = 1'b0;

        n = 0;
        while (sc_an !== 6'h3d && n < 40) begin @(negedge clk); n++; end
        chk("scan_wait_d1", n < 40, 1'b1);

        for (int j = 0; j < 7; j++) begin
            chk($sformatf("scan6_an[%0d]", j),  sc_an, an6_t[j]);
            chk($sformatf("scan6_seg[%0d]", j), sc_7,  sg6_t[j]);
            chk($sformatf("scan6_dot[%0d]", j), sc_dot, 1'b1);
            chk($sformatf("scan3_an[%0d]", j),  s3_an, an3_t[j]);
            chk($sformatf("scan3_seg[%0d]", j), s3_7,  sg3_t[j]);
            chk($sformatf("scan1_an[%0d]", j),  s1_an, 1'b0);
            chk($sformatf("scan1_seg[%0d]", j), s1_7,  7'h03);
            repeat (3) @(negedge clk);
            chk($sformatf("scan6_hold[%0d]", j), sc_an, an6_t[j]);
            chk($sformatf("scan3_hold[%0d]", j), s3_an, an3_t[j]);
            @(negedge clk);
        end
        chk("static_scan_outs", {st_7, st_dot, st_an}, {7'h7f, 1'b1, 6'h3f});

        // Asynchronous reset while digit 3 is displayed.
        n = 0;
        while (sc_an !== 6'h37 && n < 40) begin @(negedge clk); n++; end
        chk("scan_wait_d3", n < 40, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sc_an",  sc_an,  6'h3f);
        chk("arst_sc_7",   sc_7,   7'h7f);
        chk("arst_sc_dot", sc_dot, 1'b1);
        chk("arst_st_seg", st_seg, {42{1'b1}});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_an",  sc_an, 6'h3e);
        chk("post_rst_seg", sc_7,  7'h40);
        chk("post_rst_an3", s3_an, 3'b110);

        // Static: leading-zero blanking.
        number = 24'h00A3F0; lz_blank = 1'b1; dots = '0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        chk("st_lz_on",   st_seg, {7'h7f, 7'h7f, 7'h08, 7'h30, 7'h0e, 7'h40});
        chk("st_lz_dots", st_dots, 6'h3f);
        lz_blank = 1'b0;
        @(negedge clk);
        chk("st_lz_off", st_seg, {7'h40, 7'h40, 7'h08, 7'h30, 7'h0e, 7'h40});

        number = 24'h0; lz_blank = 1'b1; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        chk("st_zero", st_seg, {7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h40});

        dots = 6'b000001; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("st_dots_lat", st_dots, 6'h3f);
        @(negedge clk);
        chk("st_dots_new", st_dots, 6'h3e);

        // Blink on digit 2, with its dot requested.
        number = 24'h543210; lz_blank = 1'b0; dots = 6'b000100; blink = 6'b000100; load = 1'b1;
        @(negedge clk); load = 1'b0;
        n = 0;
        while (st_seg[20:14] !== 7'h24 && n < 40) begin @(negedge clk); n++; end
        chk("blink_wait_lit", n < 40, 1'b1);
        n = 0;
        while (st_seg[20:14] !== 7'h7f && n < 40) begin @(negedge clk); n++; end
        chk("blink_wait_dark", n < 40, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("blink_dark_seg[%0d]", k), st_seg[20:14], 7'h7f);
            chk($sformatf("blink_dark_dot[%0d]", k), st_dots[2],    1'b1);
            chk($sformatf("blink_other[%0d]", k),    st_seg[6:0],   7'h40);
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("blink_lit_seg[%0d]", k), st_seg[20:14], 7'h24);
            chk($sformatf("blink_lit_dot[%0d]", k), st_dots[2],    1'b0);
            @(negedge clk);
        end
        chk("blink_dark_again", st_seg[20:14], 7'h7f);

        // Live bus changes without load must not reach the display.
        number = 24'hFFFFFF; dots = '0; blink = '0;
        repeat (2) @(negedge clk);
        chk("live_no_load", st_seg[13:0], {7'h79, 7'h40});
        chk("live_no_load_dot", st_dots[2], st_seg[20:14] === 7'h7f ? 1'b1 : 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
